hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Drives the enable/clear side of the pipeline-register interface (en, active-low sync clear).
//  Sits beside the datapath of the 5-stage pipelined MIPS and generates per-stage enables and bubble clears.
//  Covers load-use hazards, taken-branch flushes, multi-cycle mult/div occupancy and memory wait.
//  Each stage's Register clear is the AND of the global active-low reset and this block's *_clr_b output.
// PARAMETERS
//  MULT_LAT  4   cycles a MULT/MULTU occupies HI/LO, including the EX cycle of issue
//  DIV_LAT   32  cycles a DIV/DIVU occupies HI/LO, including the EX cycle of issue
//  CNT_W     32  width of the stall-cycle performance counter
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      asynchronous, active-high reset
//  id_rs           in   5      rs field of instruction in ID
//  id_rt           in   5      rt field of instruction in ID
//  id_uses_rt      in   1      ID instruction reads rt as a source
//  id_uses_hilo    in   1      ID instruction is MFHI/MFLO/MTHI/MTLO
//  id_md_start     in   1      ID instruction is MULT/DIV (any variant)
//  ex_mem_read     in   1      EX instruction is a load
//  ex_rt           in   5      destination rt of EX instruction
//  ex_branch_taken in   1      branch/jump resolved taken in EX
//  ex_md_start     in   1      mult/div issuing in EX this cycle
//  ex_md_is_div    in   1      qualifies ex_md_start: 1=DIV, 0=MULT
//  mem_ready       in   1      data memory ready; 0 freezes the pipeline
//  pc_en           out  1      PC register enable
//  ifid_en         out  1      IF/ID enable
//  idex_en         out  1      ID/EX enable
//  exmem_en        out  1      EX/MEM enable
//  memwb_en        out  1      MEM/WB enable
//  ifid_clr_b      out  1      IF/ID sync clear, active-low
//  idex_clr_b      out  1      ID/EX sync clear (bubble insert), active-low
//  md_busy         out  1      HI/LO still being produced
//  stall_cycles    out  CNT_W  count of cycles with pc_en==0
// BEHAVIOUR
//  Reset (async, held):
//   - All *_en=0, both *_clr_b=0, md_busy=0, stall_cycles=0, state=RUN, md_cnt=0.
//   - Outputs are forced by reset combinationally.
//  Outputs are combinational from inputs plus registered state; zero-cycle latency. Priority, highest first:
//   1 FREEZE   mem_ready==0:
//              - all *_en=0, clr_b=1; md_cnt still counts down.
//   2 FLUSH    ex_branch_taken:
//              - all en=1, ifid_clr_b=0, idex_clr_b=0.
//              - Overrides any load-use or md hazard in ID.
//   3 STALL    load_use | md_hz:
//              - pc_en=0, ifid_en=0, idex_clr_b=0, idex_en=1, exmem_en=1, memwb_en=1, ifid_clr_b=1.
//   4 RUN      all en=1, all clr_b=1.
//  Hazard terms:
//   - load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//   - md_hz = md_busy & (id_uses_hilo | id_md_start).
//  FSM states: RUN, MD_BUSY.
//   - Transition RUN->MD_BUSY: on an edge with ex_md_start & mem_ready & !ex_branch_taken.
//     Load md_cnt = (ex_md_is_div ? DIV_LAT : MULT_LAT) - 2.
//   - In MD_BUSY: md_cnt decrements every cycle, including freeze cycles.
//     When md_cnt==0, go to RUN on the next edge.
//   - Special case: a latency of 1 stays in RUN.
//   - md_busy = (state==MD_BUSY).
//  Error case: ex_md_start while MD_BUSY is impossible, because ID is stalled.
//   - RTL ignores it; the bench flags it with an assertion.
//  stall_cycles:
//   - +1 on each edge where pc_en==0 and reset is low.
//   - Saturates at all-ones; never wraps.
//  Simultaneous events:
//   - freeze + branch: freeze wins; the flush is applied on the first cycle mem_ready==1.
//   - reset mid-MD: state returns to RUN immediately.
// STRUCTURE
//  Shared include mips_defs.vh holds:
//   - REG_ADDR_W=5
//   - state encodings ST_RUN=1'b0, ST_MD_BUSY=1'b1
//   - default MULT_LAT/DIV_LAT constants
//  One sub-module, md_latency_counter:
//   - loadable down-counter, width $clog2(DIV_LAT)
//   - load/value/zero ports
//  The priority mux and the perf counter stay in the top level.
// TESTING
//  T1 load-use:
//   - ex_mem_read=1, ex_rt=8, id_rs=8 -> 1 cycle pc_en=0, ifid_en=0, idex_clr_b=0.
//   - Next cycle RUN; stall_cycles=1.
//  T2 r0:
//   - ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; all en=1.
//  T3 branch vs load-use:
//   - ex_branch_taken=1 with a load-use match -> pc_en=1, ifid_clr_b=0, idex_clr_b=0.
//  T4 mult:
//   - ex_md_start=1, is_div=0, MULT_LAT=4, then id_uses_hilo=1 held -> md_busy=1 for 3 cycles.
//   - ID stalled 3 cycles; released on the 4th.
//  T5 div+freeze:
//   - DIV issue, then mem_ready=0 for 5 cycles mid-divide -> all en=0 during the freeze.
//   - md_busy drops exactly 31 cycles after issue.
//   - stall_cycles counts both the freeze and hazard cycles.
//  T6 reset:
//   - assert reset mid-divide -> outputs forced to reset values asynchronously.
//   - After deassert: state RUN, stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared definitions for the MIPS pipeline hazard / stall controller:
//   register-address width, default mult/div occupancy latencies, the
//   HI/LO occupancy FSM state type and a sizing helper for the latency
//   counter.
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int DEFAULT_MULT_LAT = 4;
    localparam int DEFAULT_DIV_LAT  = 32;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_t;

    // Counter width able to hold the larger of the two reload values
    // (latency - 2); never narrower than one bit.
    function automatic int md_cnt_width(input int mult_lat, input int div_lat);
        int lat;
        lat = (mult_lat > div_lat) ? mult_lat : div_lat;
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_latency_counter.sv
// ---------------------------------------------------------------------------
// md_latency_counter
//   Loadable down-counter tracking how many more cycles HI/LO stays busy.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-high reset (count -> 0)
//     load   in   load 'value' on the next edge (has priority over dec)
//     value  in   reload value
//     dec    in   decrement by one on the next edge (holds at zero)
//     zero   out  count is zero
// ---------------------------------------------------------------------------
module md_latency_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = value;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Enable / bubble-clear generator for the 5-stage MIPS pipeline registers.
//   Handles load-use hazards, taken-branch flushes, mult/div HI/LO occupancy
//   and data-memory wait. All control outputs are combinational from the
//   inputs and the registered occupancy state (zero-cycle latency).
//   Priority: memory freeze > branch flush > hazard stall > run.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     id_rs, id_rt, id_uses_rt   source operands of the ID instruction
//     id_uses_hilo, id_md_start  ID instruction touches HI/LO
//     ex_mem_read, ex_rt         EX load and its destination
//     ex_branch_taken            branch/jump resolved taken in EX
//     ex_md_start, ex_md_is_div  mult/div issuing in EX, and its kind
//     mem_ready                  data memory ready (0 freezes everything)
//     pc_en .. memwb_en          per-stage register enables
//     ifid_clr_b, idex_clr_b     active-low synchronous clears (bubbles)
//     md_busy                    HI/LO still being produced
//     stall_cycles               saturating count of cycles with pc_en==0
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_uses_hilo,
    input  logic                  id_md_start,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  ex_md_start,
    input  logic                  ex_md_is_div,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_clr_b,
    output logic                  idex_clr_b,
    output logic                  md_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int MD_CNT_W = md_cnt_width(MULT_LAT, DIV_LAT);

    // A latency of 1 finishes inside the issue cycle, so no busy phase.
    localparam logic MULT_MULTI = (MULT_LAT >= 2);
    localparam logic DIV_MULTI  = (DIV_LAT >= 2);

    // The busy phase lasts latency-1 cycles; the counter walks reload..0.
    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_MULTI ? MULT_LAT - 2 : 0);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_MULTI ? DIV_LAT - 2 : 0);

    md_state_t             state_reg;
    md_state_t             state_next;
    logic                  md_issue;
    logic                  md_load;
    logic [MD_CNT_W-1:0]   md_load_value;
    logic                  md_dec;
    logic                  md_cnt_zero;
    logic                  busy_state;
    logic                  load_use;
    logic                  md_hz;
    logic [CNT_W-1:0]      stall_cnt_reg;
    logic [CNT_W-1:0]      stall_cnt_next;

    // ------------------------------------------------------------------
    // HI/LO occupancy FSM
    // ------------------------------------------------------------------
    // An issue only counts when EX actually advances and is not squashed.
    assign md_issue   = ex_md_start & mem_ready & ~ex_branch_taken;
    assign busy_state = (state_reg == ST_MD_BUSY);
    assign md_dec     = busy_state;

    always_comb begin
        state_next    = state_reg;
        md_load       = 1'b0;
        md_load_value = ex_md_is_div ? DIV_LOAD : MULT_LOAD;
        case (state_reg)
            ST_RUN: begin
                if (md_issue && (ex_md_is_div ? DIV_MULTI : MULT_MULTI)) begin
                    state_next = ST_MD_BUSY;
                    md_load    = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                // A second issue here cannot happen (ID is stalled) and is ignored.
                if (md_cnt_zero) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    md_latency_counter #(
        .WIDTH (MD_CNT_W)
    ) u_md_latency_counter (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .value (md_load_value),
        .dec   (md_dec),
        .zero  (md_cnt_zero)
    );

    assign md_busy = busy_state & ~reset;

    // ------------------------------------------------------------------
    // Hazard detection and priority mux
    // ------------------------------------------------------------------
    // r0 is hardwired to zero, so a load "into" r0 creates no dependency.
    assign load_use = ex_mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign md_hz    = busy_state & (id_uses_hilo | id_md_start);

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_clr_b = 1'b1;
        idex_clr_b = 1'b1;
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_clr_b = 1'b0;
            idex_clr_b = 1'b0;
        end else if (!mem_ready) begin
            // Full freeze; a pending flush simply waits in EX until released.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_branch_taken) begin
            // The ID instruction is on the wrong path, so its hazards are moot.
            ifid_clr_b = 1'b0;
            idex_clr_b = 1'b0;
        end else if (load_use || md_hz) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let the rest drain.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_clr_b = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle performance counter (saturating)
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!pc_en && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Directed bench for hazard_stall_ctrl. Inputs change 1 ns after the rising
//   edge and outputs are sampled 1 ns later. The stall counter is built
//   narrow so that saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Packed control view: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr_b, idex_clr_b}
    localparam logic [6:0] V_RUN    = 7'b1111111;
    localparam logic [6:0] V_STALL  = 7'b0011110;
    localparam logic [6:0] V_FLUSH  = 7'b1111100;
    localparam logic [6:0] V_FREEZE = 7'b0000011;
    localparam logic [6:0] V_RESET  = 7'b0000000;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_uses_hilo;
    logic             id_md_start;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             ex_md_start;
    logic             ex_md_is_div;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_clr_b;
    logic             idex_clr_b;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [6:0]       ctrl;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MULT_LAT (4),
        .DIV_LAT  (32),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_uses_hilo    (id_uses_hilo),
        .id_md_start     (id_md_start),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .ex_md_is_div    (ex_md_is_div),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_clr_b      (ifid_clr_b),
        .idex_clr_b      (idex_clr_b),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr_b, idex_clr_b};

    // A new mult/div can never reach EX while HI/LO is still busy.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(ex_md_start && md_busy))
                else $error("mult/div issued in EX while md_busy is high");
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end else begin
            $display("ok   %s: %0h", tag, actual);
        end
    endtask

    task automatic set_idle();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        id_uses_hilo    = 1'b0;
        id_md_start     = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rt           = 5'd0;
        ex_branch_taken = 1'b0;
        ex_md_start     = 1'b0;
        ex_md_is_div    = 1'b0;
        mem_ready       = 1'b1;
    endtask

    // Check one cycle's controls, account for an expected stall, advance a cycle.
    task automatic step(input string tag, input logic [6:0] exp_ctrl, input logic exp_busy);
        #1;
        check_eq({tag, ".ctrl"}, {57'd0, ctrl}, {57'd0, exp_ctrl});
        check_eq({tag, ".busy"}, {63'd0, md_busy}, {63'd0, exp_busy});
        if (!exp_ctrl[6] && exp_stall < CNT_MAX) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string tag);
        check_eq(tag, {58'd0, stall_cycles}, 64'(exp_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_eq("rst.ctrl", {57'd0, ctrl}, {57'd0, V_RESET});
        check_eq("rst.busy", {63'd0, md_busy}, 64'd0);
        check_eq("rst.stall", {58'd0, stall_cycles}, 64'd0);
        reset = 1'b0;

        step("t0.run", V_RUN, 1'b0);
        chk_stall("t0.stall");

        // T1 load-use via rs, then via rt, then rt not used
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        step("t1.lu_rs", V_STALL, 1'b0);
        set_idle();
        check_eq("t1.stall", {58'd0, stall_cycles}, 64'd1);
        step("t1.release", V_RUN, 1'b0);
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
        step("t1.lu_rt", V_STALL, 1'b0);
        id_uses_rt = 1'b0;
        step("t1.rt_unused", V_RUN, 1'b0);

        // T2 r0 never hazards; non-load never hazards
        set_idle();
        ex_mem_read = 1'b1; id_uses_rt = 1'b1;
        step("t2.r0", V_RUN, 1'b0);
        set_idle();
        ex_rt = 5'd8; id_rs = 5'd8;
        step("t2.no_load", V_RUN, 1'b0);

        // T3 branch beats load-use; freeze beats branch; flush after release
        set_idle();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        step("t3.flush", V_FLUSH, 1'b0);
        mem_ready = 1'b0;
        step("t3.freeze_br", V_FREEZE, 1'b0);
        mem_ready = 1'b1;
        step("t3.flush_after", V_FLUSH, 1'b0);
        set_idle();
        chk_stall("t3.stall");

        // Issue gating: frozen or squashed mult must not occupy HI/LO
        ex_md_start = 1'b1; mem_ready = 1'b0;
        step("md.frozen_issue", V_FREEZE, 1'b0);
        mem_ready = 1'b1; ex_branch_taken = 1'b1;
        step("md.flushed_issue", V_FLUSH, 1'b0);
        set_idle();
        id_uses_hilo = 1'b1;
        step("md.no_busy", V_RUN, 1'b0);

        // T4 MULT: 3 busy cycles stall an MFHI, released on the 4th
        set_idle();
        ex_md_start = 1'b1;
        step("t4.issue", V_RUN, 1'b0);
        set_idle();
        id_uses_hilo = 1'b1;
        for (int k = 1; k <= 3; k++) step($sformatf("t4.busy%0d", k), V_STALL, 1'b1);
        step("t4.release", V_RUN, 1'b0);
        chk_stall("t4.stall");

        // T5 DIV with a 5-cycle freeze and a branch during the busy phase
        set_idle();
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step("t5.issue", V_RUN, 1'b0);
        set_idle();
        id_md_start = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            mem_ready       = !(k >= 10 && k <= 14);
            ex_branch_taken = (k == 20);
            if (k >= 10 && k <= 14)
                step($sformatf("t5.frz%0d", k), V_FREEZE, 1'b1);
            else if (k == 20)
                step($sformatf("t5.br%0d", k), V_FLUSH, 1'b1);
            else
                step($sformatf("t5.busy%0d", k), V_STALL, 1'b1);
        end
        mem_ready = 1'b1; ex_branch_taken = 1'b0;
        step("t5.done", V_RUN, 1'b0);
        chk_stall("t5.stall");

        // T6 asynchronous reset in the middle of a divide
        set_idle();
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step("t6.issue", V_RUN, 1'b0);
        set_idle();
        id_uses_hilo = 1'b1;
        for (int k = 1; k <= 5; k++) step($sformatf("t6.busy%0d", k), V_STALL, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6.rst_ctrl", {57'd0, ctrl}, {57'd0, V_RESET});
        check_eq("t6.rst_busy", {63'd0, md_busy}, 64'd0);
        check_eq("t6.rst_stall", {58'd0, stall_cycles}, 64'd0);
        exp_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("t6.after", V_RUN, 1'b0);
        chk_stall("t6.stall");

        // Saturation of the stall counter
        set_idle();
        mem_ready = 1'b0;
        for (int k = 1; k <= CNT_MAX + 7; k++) step($sformatf("sat.frz%0d", k), V_FREEZE, 1'b0);
        check_eq("sat.value", {58'd0, stall_cycles}, 64'(CNT_MAX));
        set_idle();
        step("sat.run", V_RUN, 1'b0);
        chk_stall("sat.hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
